fetch_stage: RTL

Instruction-fetch stage of the five-stage pipelined CPU: owns the PC register, drives instruction-cache requests, and loads the IF/ID pipeline latch. It sits directly upstream of decode and consumes the hazard unit's IF/ID enable/flush controls and the resolved branch/jump redirect from EX/MEM. It feeds the IF/ID source-register fields back to the hazard unit. It buffers a redirect that arrives during an instruction-cache miss so that an outstanding request is never aborted.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC register, I-cache request, IF/ID latch
// A redirect that arrives during a cache miss is parked until the outstanding request completes.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ifid_en,
    input  logic        ifid_flush,
    input  logic        pc_redirect,
    input  logic [31:0] pc_target,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid,
    output logic [4:0]  ifid_rs,
    output logic [4:0]  ifid_rt
);

    typedef enum logic [1:0] {
        S_RUN           = 2'd0,
        S_WAIT_REDIRECT = 2'd1,
        S_HALTED        = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = pc_target & ~32'h0000_0003;

    // PC / redirect FSM. The live request is never dropped: a redirect on a
    // miss waits for the pending ihit, whose word is then thrown away.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (pc_redirect && ihit) begin
                    pc_d = target_aligned;
                end else if (pc_redirect) begin
                    redirect_pc_d = target_aligned;
                    state_d       = S_WAIT_REDIRECT;
                end else if (ihit && ifid_en) begin
                    pc_d = pc_plus4;
                end
            end
            S_WAIT_REDIRECT: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    if (pc_redirect) begin
                        redirect_pc_d = target_aligned;
                    end
                    if (ihit) begin
                        // The youngest redirect is the architecturally correct one.
                        pc_d    = pc_redirect ? target_aligned : redirect_pc_q;
                        state_d = S_RUN;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    // IF/ID latch: only a RUN-state hit without a same-cycle redirect carries a real word.
    always_comb begin
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;
        if (ifid_flush || halt || (state_q == S_HALTED)) begin
            ifid_instr_d   = 32'h0000_0000;
            ifid_pcplus4_d = 32'h0000_0000;
            ifid_valid_d   = 1'b0;
        end else if (!ifid_en) begin
            ifid_instr_d   = ifid_instr_q;
            ifid_pcplus4_d = ifid_pcplus4_q;
            ifid_valid_d   = ifid_valid_q;
        end else if ((state_q == S_RUN) && ihit && !pc_redirect) begin
            ifid_instr_d   = iload;
            ifid_pcplus4_d = pc_plus4;
            ifid_valid_d   = 1'b1;
        end else begin
            ifid_instr_d   = 32'h0000_0000;
            ifid_pcplus4_d = 32'h0000_0000;
            ifid_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_RUN;
            pc_q           <= PC_INIT;
            redirect_pc_q  <= 32'h0000_0000;
            ifid_instr_q   <= 32'h0000_0000;
            ifid_pcplus4_q <= 32'h0000_0000;
            ifid_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            redirect_pc_q  <= redirect_pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
        end
    end

    assign iREN         = (state_q != S_HALTED);
    assign iaddr        = pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pcplus4 = ifid_pcplus4_q;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_rs      = ifid_instr_q[25:21];
    assign ifid_rt      = ifid_instr_q[20:16];

endmodule
